ex_operand_stage: RTL and testbench

Execute-side consumer of the ID/EX pipeline register contents. It buffers one decoded instruction, plus one skid entry, behind a valid/ready handshake. It resolves RAW operands by forwarding from EX/MEM and MEM/WB, and it gates issue on load-use hazards. It delivers final ALU operands, store data and pass-through control to the ALU and EX/MEM register.

---
 rtl/ex_operand_stage.sv | 197 +++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// Execute-side operand stage: two-entry (head + skid) buffer behind a valid/ready handshake,
// with RAW forwarding from EX/MEM and MEM/WB when EX_FWD_EN is defined (stall-only otherwise).
module ex_operand_stage #(
  parameter int DATA_WIDTH    = 64,
  parameter int REG_ID_WIDTH  = 5,
  parameter int EX_CTRL_WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_data1,
  input  logic [DATA_WIDTH-1:0]    in_data2,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [REG_ID_WIDTH-1:0]  in_dest,
  input  logic [REG_ID_WIDTH-1:0]  in_reg1,
  input  logic [REG_ID_WIDTH-1:0]  in_reg2,
  input  logic [EX_CTRL_WIDTH-1:0] in_ex_ctrl,
  input  logic [2:0]               in_mem_ctrl,
  input  logic [1:0]               in_wb_ctrl,
  input  logic [REG_ID_WIDTH-1:0]  exm_dest,
  input  logic                     exm_reg_write,
  input  logic                     exm_mem_read,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic [REG_ID_WIDTH-1:0]  mwb_dest,
  input  logic                     mwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    mwb_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]    out_op_a,
  output logic [DATA_WIDTH-1:0]    out_op_b,
  output logic [DATA_WIDTH-1:0]    out_store_data,
  output logic [REG_ID_WIDTH-1:0]  out_dest,
  output logic [EX_CTRL_WIDTH-1:0] out_ex_ctrl,
  output logic [2:0]               out_mem_ctrl,
  output logic [1:0]               out_wb_ctrl,
  output logic                     hazard_stall
);

  localparam int REG_TO_PC_BIT = EX_CTRL_WIDTH - 1;
  localparam int ALU_SRC_BIT   = EX_CTRL_WIDTH - 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    data1;
    logic [DATA_WIDTH-1:0]    data2;
    logic [DATA_WIDTH-1:0]    imm;
    logic [REG_ID_WIDTH-1:0]  dest;
    logic [REG_ID_WIDTH-1:0]  reg1;
    logic [REG_ID_WIDTH-1:0]  reg2;
    logic [EX_CTRL_WIDTH-1:0] ex_ctrl;
    logic [2:0]               mem_ctrl;
    logic [1:0]               wb_ctrl;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic logic id_hit(input logic [REG_ID_WIDTH-1:0] id,
                                  input logic                    wr,
                                  input logic [REG_ID_WIDTH-1:0] dest);
    return wr && (id != '0) && (id == dest);
  endfunction

  function automatic entry_t wb_capture(input entry_t                  e,
                                        input logic                    wr,
                                        input logic [REG_ID_WIDTH-1:0] dest,
                                        input logic [DATA_WIDTH-1:0]   val);
    entry_t r;
    r = e;
    if (id_hit(e.reg1, wr, dest)) r.data1 = val;
    if (id_hit(e.reg2, wr, dest)) r.data2 = val;
    return r;
  endfunction

  state_t state_q, state_d;
  logic   in_ready_q;
  entry_t head_p0, skid_p0, head_d, skid_d, in_entry;
  logic   load_head_in, load_skid_in, move_skid;
  logic   acc, iss, vld_p0, hazard;
  logic   [DATA_WIDTH-1:0] op1, op2;

  always_comb begin
    in_entry.pc       = in_pc;
    in_entry.data1    = in_data1;
    in_entry.data2    = in_data2;
    in_entry.imm      = in_imm;
    in_entry.dest     = in_dest;
    in_entry.reg1     = in_reg1;
    in_entry.reg2     = in_reg2;
    in_entry.ex_ctrl  = in_ex_ctrl;
    in_entry.mem_ctrl = in_mem_ctrl;
    in_entry.wb_ctrl  = in_wb_ctrl;
  end

  assign acc = in_valid & in_ready_q;
  assign iss = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    load_head_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    case (state_q)
      EMPTY: if (acc) begin
        state_d      = ONE;
        load_head_in = 1'b1;
      end
      ONE: begin
        if (acc && !iss) begin
          state_d      = TWO;
          load_skid_in = 1'b1;
        end else if (acc && iss) begin
          load_head_in = 1'b1;
        end else if (iss) begin
          state_d = EMPTY;
        end
      end
      TWO: if (iss) begin
        state_d   = ONE;
        move_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      load_head_in = 1'b0;
      load_skid_in = 1'b0;
      move_skid    = 1'b0;
    end
  end

  // Held entries absorb MEM/WB writes every cycle so they never go stale across stalls
  always_comb begin
    head_d = head_p0;
    skid_d = skid_p0;
    if (load_head_in)   head_d = in_entry;
    else if (move_skid) head_d = skid_p0;
    if (load_skid_in)   skid_d = in_entry;
    head_d = wb_capture(head_d, mwb_reg_write, mwb_dest, mwb_result);
    skid_d = wb_capture(skid_d, mwb_reg_write, mwb_dest, mwb_result);
  end

  // Stage p0: head/skid storage; head is cleared on reset because it drives the outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_p0    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      head_p0    <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_p0 <= skid_d;
  end

  assign vld_p0 = (state_q != EMPTY);

`ifdef EX_FWD_EN
  logic e1, e2, m1, m2;
  assign e1 = id_hit(head_p0.reg1, exm_reg_write, exm_dest);
  assign e2 = id_hit(head_p0.reg2, exm_reg_write, exm_dest);
  assign m1 = id_hit(head_p0.reg1, mwb_reg_write, mwb_dest);
  assign m2 = id_hit(head_p0.reg2, mwb_reg_write, mwb_dest);
  assign hazard = exm_mem_read & (e1 | e2);
  assign op1 = (e1 && !exm_mem_read) ? exm_result : (m1 ? mwb_result : head_p0.data1);
  assign op2 = (e2 && !exm_mem_read) ? exm_result : (m2 ? mwb_result : head_p0.data2);
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{exm_result, exm_mem_read};
  assign hazard = id_hit(head_p0.reg1, exm_reg_write, exm_dest) |
                  id_hit(head_p0.reg2, exm_reg_write, exm_dest) |
                  id_hit(head_p0.reg1, mwb_reg_write, mwb_dest) |
                  id_hit(head_p0.reg2, mwb_reg_write, mwb_dest);
  assign op1 = head_p0.data1;
  assign op2 = head_p0.data2;
`endif

  assign in_ready       = in_ready_q;
  assign hazard_stall   = vld_p0 & hazard;
  assign out_valid      = vld_p0 & ~hazard;
  assign out_pc         = head_p0.pc;
  assign out_op_a       = head_p0.ex_ctrl[REG_TO_PC_BIT] ? head_p0.pc : op1;
  assign out_op_b       = head_p0.ex_ctrl[ALU_SRC_BIT] ? head_p0.imm : op2;
  assign out_store_data = op2;
  assign out_dest       = head_p0.dest;
  assign out_ex_ctrl    = head_p0.ex_ctrl;
  assign out_mem_ctrl   = head_p0.mem_ctrl;
  assign out_wb_ctrl    = head_p0.wb_ctrl;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized bench for ex_operand_stage against a queue-based model of the held entries.
module tb_ex_operand_stage;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int CW = 19;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready, hazard_stall;
  logic [DW-1:0] in_pc, in_data1, in_data2, in_imm;
  logic [RW-1:0] in_dest, in_reg1, in_reg2;
  logic [CW-1:0] in_ex_ctrl;
  logic [2:0]    in_mem_ctrl;
  logic [1:0]    in_wb_ctrl;
  logic [RW-1:0] exm_dest, mwb_dest;
  logic          exm_reg_write, exm_mem_read, mwb_reg_write;
  logic [DW-1:0] exm_result, mwb_result;
  logic [DW-1:0] out_pc, out_op_a, out_op_b, out_store_data;
  logic [RW-1:0] out_dest;
  logic [CW-1:0] out_ex_ctrl;
  logic [2:0]    out_mem_ctrl;
  logic [1:0]    out_wb_ctrl;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  ex_operand_stage #(.DATA_WIDTH(DW), .REG_ID_WIDTH(RW), .EX_CTRL_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm),
    .in_dest(in_dest), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_ex_ctrl(in_ex_ctrl),
    .in_mem_ctrl(in_mem_ctrl), .in_wb_ctrl(in_wb_ctrl), .exm_dest(exm_dest),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read), .exm_result(exm_result),
    .mwb_dest(mwb_dest), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op_a(out_op_a),
    .out_op_b(out_op_b), .out_store_data(out_store_data), .out_dest(out_dest),
    .out_ex_ctrl(out_ex_ctrl), .out_mem_ctrl(out_mem_ctrl), .out_wb_ctrl(out_wb_ctrl),
    .hazard_stall(hazard_stall)
  );

  typedef struct packed {
    logic [DW-1:0] pc, d1, d2, imm;
    logic [RW-1:0] dest, r1, r2;
    logic [CW-1:0] exc;
    logic [2:0]    memc;
    logic [1:0]    wbc;
  } ent_t;

  ent_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [RW-1:0] id, input logic wr, input logic [RW-1:0] d);
    return wr && (id != 0) && (id == d);
  endfunction

  function automatic bit stall_of(input ent_t h);
`ifdef EX_FWD_EN
    return exm_mem_read && (hit(h.r1, exm_reg_write, exm_dest) || hit(h.r2, exm_reg_write, exm_dest));
`else
    return hit(h.r1, exm_reg_write, exm_dest) || hit(h.r2, exm_reg_write, exm_dest) ||
           hit(h.r1, mwb_reg_write, mwb_dest) || hit(h.r2, mwb_reg_write, mwb_dest);
`endif
  endfunction

  function automatic logic [DW-1:0] resolve(input logic [RW-1:0] id, input logic [DW-1:0] stored);
`ifdef EX_FWD_EN
    if (hit(id, exm_reg_write, exm_dest) && !exm_mem_read) return exm_result;
    if (hit(id, mwb_reg_write, mwb_dest)) return mwb_result;
`endif
    return stored;
  endfunction

  function automatic ent_t cur_in();
    ent_t e;
    e.pc = in_pc; e.d1 = in_data1; e.d2 = in_data2; e.imm = in_imm;
    e.dest = in_dest; e.r1 = in_reg1; e.r2 = in_reg2;
    e.exc = in_ex_ctrl; e.memc = in_mem_ctrl; e.wbc = in_wb_ctrl;
    return e;
  endfunction

  task automatic check_cycle();
    ent_t h;
    bit st;
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() == 0) begin
      chk("out_valid_empty", out_valid, 0);
      chk("hazard_empty", hazard_stall, 0);
    end else begin
      h  = q[0];
      st = stall_of(h);
      chk("hazard_stall", hazard_stall, st);
      chk("out_valid", out_valid, !st);
      chk("out_pc", out_pc, h.pc);
      chk("out_op_a", out_op_a, h.exc[18] ? h.pc : resolve(h.r1, h.d1));
      chk("out_op_b", out_op_b, h.exc[17] ? h.imm : resolve(h.r2, h.d2));
      chk("out_store_data", out_store_data, resolve(h.r2, h.d2));
      chk("out_dest", out_dest, h.dest);
      chk("out_ctrl", {out_ex_ctrl, out_mem_ctrl, out_wb_ctrl}, {h.exc, h.memc, h.wbc});
    end
  endtask

  task automatic update_model();
    bit acc, iss;
    if (!reset) begin
      q.delete();
      return;
    end
    acc = in_valid && (q.size() < 2);
    iss = (q.size() > 0) && !stall_of(q[0]) && out_ready;
    if (flush) q.delete();
    else begin
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(cur_in());
    end
    foreach (q[i]) begin
      if (hit(q[i].r1, mwb_reg_write, mwb_dest)) q[i].d1 = mwb_result;
      if (hit(q[i].r2, mwb_reg_write, mwb_dest)) q[i].d2 = mwb_result;
    end
  endtask

  task automatic tick();
    #1;
    check_cycle();
    update_model();
    @(negedge clk);
  endtask

  task automatic idle_ctl();
    flush = 0; exm_reg_write = 0; exm_mem_read = 0; mwb_reg_write = 0;
    exm_dest = 0; mwb_dest = 0; exm_result = 0; mwb_result = 0;
  endtask

  task automatic rand_entry();
    in_pc = {$urandom, $urandom}; in_data1 = {$urandom, $urandom};
    in_data2 = {$urandom, $urandom}; in_imm = {$urandom, $urandom};
    in_dest = RW'($urandom_range(0, 7)); in_reg1 = RW'($urandom_range(0, 7));
    in_reg2 = RW'($urandom_range(0, 7)); in_ex_ctrl = CW'($urandom);
    in_mem_ctrl = 3'($urandom); in_wb_ctrl = 2'($urandom);
  endtask

  task automatic set_entry(input logic [DW-1:0] pc, input logic [RW-1:0] r1, input logic [DW-1:0] d1,
                           input logic [RW-1:0] r2, input logic [DW-1:0] d2);
    rand_entry();
    in_pc = pc; in_reg1 = r1; in_data1 = d1; in_reg2 = r2; in_data2 = d2;
    in_ex_ctrl[18] = 1'b0; in_ex_ctrl[17] = 1'b0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1; idle_ctl();
    tick(); tick(); tick();
  endtask

  logic [DW-1:0] prev_pc, pa, pb, pc_c;

  initial begin
    reset = 0; in_valid = 0; out_ready = 0; idle_ctl(); rand_entry();
    @(negedge clk);
    tick(); tick();
    chk("rst_op_a", out_op_a, 0);
    chk("rst_pc", out_pc, 0);
    reset = 1;

    // entry held, then asynchronous reset with the clock stopped
    in_valid = 1; set_entry(64'hAAAA, 5'd1, 64'h11, 5'd2, 64'h22); in_ex_ctrl = '1; in_imm = 64'h77;
    tick();
    in_valid = 0;
    tick();
    clk_en = 0;
    reset = 0;
    q.delete();
    #3;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_hazard", hazard_stall, 0);
    chk("async_rst_data", {out_pc, out_op_a, out_op_b, out_store_data}, 0);
    chk("async_rst_ctrl", {out_dest, out_ex_ctrl, out_mem_ctrl, out_wb_ctrl}, 0);
    #20;
    clk_en = 1;
    @(negedge clk);
    tick();
    reset = 1;
    tick();

    // back-to-back, no hazards
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; rand_entry();
      #1;
      chk("b2b_in_ready", in_ready, 1);
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_latency_pc", out_pc, prev_pc);
      end
      prev_pc = in_pc;
      tick();
    end
    drain();

    // skid: three offers while out_ready is low
    out_ready = 0; in_valid = 1;
    set_entry(64'hA0, 0, 0, 0, 0); pa = in_pc; tick();
    set_entry(64'hB0, 0, 0, 0, 0); pb = in_pc; #1; chk("skid_ready_c1", in_ready, 1); tick();
    set_entry(64'hC0, 0, 0, 0, 0); pc_c = in_pc;
    #1; chk("skid_ready_full", in_ready, 0); chk("skid_head_a", out_pc, pa); tick();
    out_ready = 1;
    #1; chk("skid_ready_issue", in_ready, 0); chk("skid_issue_a", out_pc, pa); tick();
    #1; chk("skid_ready_back", in_ready, 1); chk("skid_order_b", out_pc, pb); tick();
    in_valid = 0;
    #1; chk("skid_order_c", out_pc, pc_c); tick();
    drain();

    // EX/MEM over MEM/WB priority, and x0 never matching
    out_ready = 0; in_valid = 1; set_entry(64'h500, 5'd5, 64'h111, 5'd0, 64'h0); tick();
    in_valid = 0;
    exm_reg_write = 1; exm_dest = 5; exm_result = 64'h10;
    mwb_reg_write = 1; mwb_dest = 5; mwb_result = 64'h20;
    #1;
`ifdef EX_FWD_EN
    chk("fwd_priority", out_op_a, 64'h10);
    chk("fwd_valid", out_valid, 1);
`else
    chk("nofwd_stall", hazard_stall, 1);
`endif
    tick();
    drain();
    out_ready = 0; in_valid = 1; set_entry(64'h600, 5'd0, 64'h1234, 5'd0, 64'h5); tick();
    in_valid = 0; out_ready = 1;
    exm_reg_write = 1; exm_dest = 0; exm_result = 64'h10;
    mwb_reg_write = 1; mwb_dest = 0; mwb_result = 64'h20;
    #1; chk("x0_stored", out_op_a, 64'h1234); chk("x0_valid", out_valid, 1);
    tick();
    drain();

    // load-use on reg2
    in_valid = 1; set_entry(64'h700, 5'd0, 64'h0, 5'd7, 64'h55); tick();
    in_valid = 0;
    exm_reg_write = 1; exm_mem_read = 1; exm_dest = 7; exm_result = 64'hBAD;
    #1; chk("lu_stall", hazard_stall, 1); chk("lu_valid", out_valid, 0);
    tick();
    idle_ctl(); mwb_reg_write = 1; mwb_dest = 7; mwb_result = 64'hDEAD;
`ifdef EX_FWD_EN
    #1; chk("lu_fwd_op_b", out_op_b, 64'hDEAD); chk("lu_fwd_valid", out_valid, 1);
    tick();
`else
    #1; chk("lu_nofwd_stall2", hazard_stall, 1);
    tick();
    idle_ctl();
    #1; chk("lu_capture_op_b", out_op_b, 64'hDEAD); chk("lu_capture_valid", out_valid, 1);
    tick();
`endif
    drain();

`ifndef EX_FWD_EN
    // ALU producer: stall through EX/MEM and MEM/WB, then issue with captured value
    in_valid = 1; set_entry(64'h800, 5'd3, 64'h7, 5'd0, 64'h0); tick();
    in_valid = 0; exm_reg_write = 1; exm_dest = 3; exm_result = 64'h99;
    #1; chk("alu_stall1", hazard_stall, 1); tick();
    idle_ctl(); mwb_reg_write = 1; mwb_dest = 3; mwb_result = 64'h99;
    #1; chk("alu_stall2", hazard_stall, 1); tick();
    idle_ctl();
    #1; chk("alu_captured", out_op_a, 64'h99); chk("alu_issue", out_valid, 1); tick();
    drain();
`endif

    // flush in TWO with a same-cycle offer
    out_ready = 0; in_valid = 1;
    rand_entry(); tick();
    rand_entry(); tick();
    flush = 1; rand_entry();
    #1; chk("flush_pre_ready", in_ready, 0); tick();
    flush = 0; in_valid = 0;
    #1; chk("flush_valid", out_valid, 0); chk("flush_ready", in_ready, 1); tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      flush = ($urandom_range(0, 31) == 0);
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_entry();
      exm_reg_write = $urandom_range(0, 1); exm_mem_read = $urandom_range(0, 1);
      exm_dest = RW'($urandom_range(0, 7)); exm_result = {$urandom, $urandom};
      mwb_reg_write = $urandom_range(0, 1);
      mwb_dest = RW'($urandom_range(0, 7)); mwb_result = {$urandom, $urandom};
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
